// File: rtl/rail_rush_pkg.sv
// Rail Rush shared types: gesture commands, player states, lane geometry and obstacle codes.
// Shared by the player controller and the obstacle collision logic.
package rail_rush_pkg;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_LEFT  = 3'd1,
      CMD_RIGHT = 3'd2,
      CMD_JUMP  = 3'd3,
      CMD_SLIDE = 3'd4
   } cmd_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_JUMP  = 2'd1,
      ST_SLIDE = 2'd2,
      ST_STUN  = 2'd3
   } player_state_t;

   // Obstacle codes: LOW is cleared by jumping, HIGH by sliding, FULL only by changing lane.
   typedef enum logic [1:0] {
      OBS_NONE = 2'd0,
      OBS_LOW  = 2'd1,
      OBS_HIGH = 2'd2,
      OBS_FULL = 2'd3
   } obstacle_t;

   localparam logic [9:0] LANE0_X = 10'd144;
   localparam logic [9:0] LANE1_X = 10'd400;
   localparam logic [9:0] LANE2_X = 10'd656;
   localparam logic [9:0] VP_X    = 10'd400;
   localparam logic [9:0] VP_Y    = 10'd120;

   function automatic logic [9:0] lane_centre(input logic [1:0] lane);
      case (lane)
         2'd0:    return LANE0_X;
         2'd2:    return LANE2_X;
         default: return LANE1_X;
      endcase
   endfunction

   function automatic logic cmd_is_real(input logic [2:0] c);
      return (c >= 3'd1) && (c <= 3'd4);
   endfunction

endpackage

// File: rtl/player_cmd_buffer.sv
// One-entry holding register for gesture commands; NONE and codes 5-7 are accepted and discarded.
// The FSM pops an entry when it consumes or drops it, and may hold it to keep it pending.
module player_cmd_buffer
   import rail_rush_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       flush,
   input  logic       cmd_valid,
   input  logic [2:0] cmd,
   input  logic       pop,
   input  logic       hold,
   output logic       cmd_ready,
   output logic       pend_valid,
   output cmd_t       pend_cmd
);

   // Holding register: load only when empty, so load and pop never coincide.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         pend_valid <= 1'b0;
         pend_cmd   <= CMD_NONE;
      end else if (cmd_valid && !pend_valid) begin
         pend_valid <= cmd_is_real(cmd);
         pend_cmd   <= cmd_is_real(cmd) ? cmd_t'(cmd) : CMD_NONE;
      end else if (pop && !hold) begin
         pend_valid <= 1'b0;
         pend_cmd   <= CMD_NONE;
      end else begin
         pend_valid <= pend_valid;
         pend_cmd   <= pend_cmd;
      end
   end

   assign cmd_ready = !pend_valid;

endmodule

// File: rtl/player_controller.sv
// Rail Rush player state: lane/jump/slide/stun FSM stepped once per frame, plus sprite pixel.
// Optional INPUT_BUFFER_EN keeps an illegal JUMP/SLIDE pending until the player is back in RUN.
module player_controller
   import rail_rush_pkg::*;
#(
   parameter int JUMP_FRAMES  = 30,
   parameter int SLIDE_FRAMES = 24,
   parameter int STUN_FRAMES  = 45,
   parameter int LANE_STEP    = 32,
   parameter int PLAYER_Y     = 490,
   parameter int PLAYER_HW    = 20,
   parameter int PLAYER_H     = 60
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       frame_done,
   input  logic       game_active,
   input  logic       cmd_valid,
   input  logic [2:0] cmd,
   output logic       cmd_ready,
   input  logic       hit,
   input  logic [9:0] row,
   input  logic [9:0] col,
   output logic [1:0] player_lane,
   output logic       jump_clear,
   output logic       slide_clear,
   output logic [9:0] player_x,
   output logic       stunned,
   output logic       player_pixel
);

   localparam logic [5:0] JUMP_T  = 6'(JUMP_FRAMES - 1);
   localparam logic [5:0] SLIDE_T = 6'(SLIDE_FRAMES - 1);
   localparam logic [5:0] STUN_T  = 6'(STUN_FRAMES - 1);
   localparam logic [9:0] STEP    = 10'(LANE_STEP);

   player_state_t state, state_n;
   logic [5:0]    timer, timer_n;
   logic [1:0]    lane_n;
   logic [9:0]    x_n, target;
   logic [2:0]    frame_cnt;
   logic          frame, pop, hold, pend_valid, pixel_n;
   cmd_t          pend_cmd;
   logic [5:0]    t;
   logic [11:0]   prod;
   logic [9:0]    y_off, h;
   logic          in_col, in_row;

   assign frame = frame_done && game_active;

   player_cmd_buffer u_buf (
      .clock      (clock),
      .reset      (reset),
      .flush      (!game_active),
      .cmd_valid  (cmd_valid),
      .cmd        (cmd),
      .pop        (pop),
      .hold       (hold),
      .cmd_ready  (cmd_ready),
      .pend_valid (pend_valid),
      .pend_cmd   (pend_cmd)
   );

   // Per-frame next state: hit, stun countdown, jump/slide countdown, then the pending command.
   always_comb begin
      state_n = state;
      timer_n = timer;
      lane_n  = player_lane;
      pop     = 1'b0;
      hold    = 1'b0;
      if (frame) begin
         if (hit && (state != ST_STUN)) begin
            state_n = ST_STUN;
            timer_n = STUN_T;
            pop     = 1'b1;
         end else if (state == ST_STUN) begin
            pop = 1'b1;
            if (timer == 6'd0) state_n = ST_RUN;
            else               timer_n = timer - 6'd1;
         end else begin
            if ((state == ST_JUMP) || (state == ST_SLIDE)) begin
               if (timer == 6'd0) state_n = ST_RUN;
               else               timer_n = timer - 6'd1;
            end else begin
               state_n = state;
            end
            if (pend_valid) begin
               pop = 1'b1;
               case (pend_cmd)
                  CMD_LEFT:  lane_n = (player_lane == 2'd0) ? 2'd0 : player_lane - 2'd1;
                  CMD_RIGHT: lane_n = (player_lane >= 2'd2) ? 2'd2 : player_lane + 2'd1;
                  CMD_JUMP, CMD_SLIDE: begin
                     if (state_n == ST_RUN) begin
                        state_n = (pend_cmd == CMD_JUMP) ? ST_JUMP : ST_SLIDE;
                        timer_n = (pend_cmd == CMD_JUMP) ? JUMP_T : SLIDE_T;
                     end else begin
`ifdef INPUT_BUFFER_EN
                        hold = 1'b1;
`else
                        hold = 1'b0;
`endif
                     end
                  end
                  default: lane_n = player_lane;
               endcase
            end else begin
               pop = 1'b0;
            end
         end
      end else begin
         state_n = state;
      end
   end

   // Horizontal animation toward the (new) lane centre, clamping on arrival.
   always_comb begin
      target = lane_centre(lane_n);
      x_n    = player_x;
      if (frame) begin
         if (player_x < target)
            x_n = ((target - player_x) <= STEP) ? target : player_x + STEP;
         else if (player_x > target)
            x_n = ((player_x - target) <= STEP) ? target : player_x - STEP;
         else
            x_n = player_x;
      end else begin
         x_n = player_x;
      end
   end

   // Sprite box from the current registered state; jump arc is a parabola in frames elapsed.
   always_comb begin
      t      = JUMP_T - timer;
      prod   = 12'(t) * 12'(JUMP_T - t);
      y_off  = (state == ST_JUMP) ? 10'(prod >> 3) : 10'd0;
      h      = (state == ST_SLIDE) ? 10'(PLAYER_H / 2) : 10'(PLAYER_H);
      in_col = (({1'b0, col} + 11'(PLAYER_HW)) >= {1'b0, player_x}) &&
               ({1'b0, col} < ({1'b0, player_x} + 11'(PLAYER_HW)));
      in_row = (({1'b0, row} + {1'b0, h} + {1'b0, y_off}) >= 11'(PLAYER_Y)) &&
               (({1'b0, row} + {1'b0, y_off}) < 11'(PLAYER_Y));
      pixel_n = in_col && in_row && !((state == ST_STUN) && frame_cnt[2]);
   end

   // State and output registers; game_active low holds the idle pose.
   always_ff @(posedge clock) begin
      if (reset || !game_active) begin
         state        <= ST_RUN;
         timer        <= 6'd0;
         player_lane  <= 2'd1;
         player_x     <= LANE1_X;
         frame_cnt    <= 3'd0;
         jump_clear   <= 1'b0;
         slide_clear  <= 1'b0;
         stunned      <= 1'b0;
         player_pixel <= 1'b0;
      end else begin
         state        <= state_n;
         timer        <= timer_n;
         player_lane  <= lane_n;
         player_x     <= x_n;
         frame_cnt    <= frame ? frame_cnt + 3'd1 : frame_cnt;
         jump_clear   <= (state_n == ST_JUMP);
         slide_clear  <= (state_n == ST_SLIDE);
         stunned      <= (state_n == ST_STUN);
         player_pixel <= pixel_n;
      end
   end

endmodule

// File: tb/tb_player_controller.sv
// Directed bench for player_controller; expected values are hand-derived from the frame rules.
// Build with INPUT_BUFFER_EN defined to cover the buffered-command variant.
module tb_player_controller;
   import rail_rush_pkg::*;

   logic       clock = 1'b0;
   logic       reset, frame_done, game_active, cmd_valid, hit;
   logic [2:0] cmd;
   logic [9:0] row, col;
   logic       cmd_ready, jump_clear, slide_clear, stunned, player_pixel;
   logic [1:0] player_lane;
   logic [9:0] player_x;
   int         n_checks = 0;
   int         n_pass = 0;

   player_controller dut (
      .clock        (clock),
      .reset        (reset),
      .frame_done   (frame_done),
      .game_active  (game_active),
      .cmd_valid    (cmd_valid),
      .cmd          (cmd),
      .cmd_ready    (cmd_ready),
      .hit          (hit),
      .row          (row),
      .col          (col),
      .player_lane  (player_lane),
      .jump_clear   (jump_clear),
      .slide_clear  (slide_clear),
      .player_x     (player_x),
      .stunned      (stunned),
      .player_pixel (player_pixel)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic frame();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      tick();
   endtask

   task automatic send(input logic [2:0] c);
      cmd_valid = 1'b1;
      cmd = c;
      tick();
      cmd_valid = 1'b0;
      cmd = 3'd0;
   endtask

   task automatic check_pix(input logic [9:0] r, input logic [9:0] c, input int exp, input string tag);
      row = r;
      col = c;
      tick();
      check_eq(tag, player_pixel, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int sum;
      reset = 1'b1; frame_done = 1'b0; game_active = 1'b1; cmd_valid = 1'b0;
      hit = 1'b0; cmd = 3'd0; row = 10'd0; col = 10'd0;
      tick(); tick();
      check_eq("rst_lane", player_lane, 1);
      check_eq("rst_x", player_x, 400);
      check_eq("rst_ready", cmd_ready, 1);
      check_eq("rst_flags", {jump_clear, slide_clear, stunned}, 0);
      reset = 1'b0;

      // 1: idle frames
      for (int i = 0; i < 12; i++) frame();
      check_eq("idle_lane", player_lane, 1);
      check_eq("idle_x", player_x, 400);
      check_eq("idle_ready", cmd_ready, 1);
      check_eq("idle_flags", {jump_clear, slide_clear, stunned}, 0);

      // 2: LEFT and slide animation to lane 0
      send(3'(CMD_LEFT));
      check_eq("left_pend_ready", cmd_ready, 0);
      frame();
      check_eq("left_lane", player_lane, 0);
      check_eq("left_x1", player_x, 368);
      check_eq("left_ready", cmd_ready, 1);
      frame();
      check_eq("left_x2", player_x, 336);
      for (int i = 0; i < 6; i++) frame();
      check_eq("left_x_end", player_x, 144);
      frame();
      check_eq("left_x_hold", player_x, 144);
      send(3'(CMD_LEFT));
      frame();
      check_eq("left_sat_lane", player_lane, 0);
      check_eq("left_sat_x", player_x, 144);
      send(3'd6);
      check_eq("bad_code_ready", cmd_ready, 1);

      // sprite box edges at x=144, standing rows [430,490)
      check_pix(10'd489, 10'd144, 1, "pix_bottom_in");
      check_pix(10'd490, 10'd144, 0, "pix_bottom_out");
      check_pix(10'd430, 10'd124, 1, "pix_top_left_in");
      check_pix(10'd429, 10'd144, 0, "pix_top_out");
      check_pix(10'd430, 10'd163, 1, "pix_right_in");
      check_pix(10'd430, 10'd164, 0, "pix_right_out");
      check_pix(10'd450, 10'd123, 0, "pix_left_out");

      // 3: JUMP lasts 30 frames; SLIDE offered during it
      row = 10'd404; col = 10'd144;
      send(3'(CMD_JUMP));
      frame();
      check_eq("jump_start", jump_clear, 1);
      check_eq("jump_pix_ground", player_pixel, 0);
      n = 1;
      send(3'(CMD_SLIDE));
      for (int i = 0; i < 40; i++) begin
         frame();
         if (!jump_clear) break;
         n++;
         if (n == 15) check_eq("jump_apex_pix", player_pixel, 1);
      end
      check_eq("jump_frames", n, 30);
`ifdef INPUT_BUFFER_EN
      check_eq("buf_slide_start", slide_clear, 1);
      n = 1;
      for (int i = 0; i < 40; i++) begin
         frame();
         if (!slide_clear) break;
         n++;
      end
      check_eq("buf_slide_frames", n, 24);
`else
      check_eq("drop_slide", slide_clear, 0);
`endif
      check_eq("after_jump_ready", cmd_ready, 1);

      // 4: SLIDE sprite, then hit mid-slide
      send(3'(CMD_SLIDE));
      frame();
      check_eq("slide_start", slide_clear, 1);
      check_pix(10'd450, 10'd144, 0, "slide_pix_above");
      check_pix(10'd470, 10'd144, 1, "slide_pix_in");
      frame();
      hit = 1'b1;
      frame();
      hit = 1'b0;
      check_eq("hit_stunned", stunned, 1);
      check_eq("hit_slide_off", slide_clear, 0);
      n = 1;
      sum = 0;
      row = 10'd460; col = 10'd144;
      send(3'(CMD_RIGHT));
      for (int i = 0; i < 60; i++) begin
         frame();
         if (!stunned) break;
         n++;
         if (n >= 2 && n <= 9) sum += int'(player_pixel);
      end
      check_eq("stun_frames", n, 45);
      check_eq("stun_flicker", sum, 4);
      check_eq("stun_lane", player_lane, 0);
      check_eq("stun_ready", cmd_ready, 1);

      // 5: command coincident with frame_done waits a frame; second is back-pressured
      cmd_valid = 1'b1; cmd = 3'(CMD_RIGHT); frame_done = 1'b1;
      tick();
      frame_done = 1'b0; cmd = 3'(CMD_JUMP);
      check_eq("coinc_lane", player_lane, 0);
      check_eq("coinc_ready", cmd_ready, 0);
      tick();
      check_eq("second_held", cmd_ready, 0);
      frame();
      cmd_valid = 1'b0; cmd = 3'd0;
      check_eq("coinc_exec_lane", player_lane, 1);
      check_eq("second_pending", cmd_ready, 0);
      check_eq("second_not_yet", jump_clear, 0);
      frame();
      check_eq("second_exec", jump_clear, 1);

      // 6: game_active drop mid-JUMP with a pending command
      send(3'(CMD_LEFT));
      check_eq("pre_drop_ready", cmd_ready, 0);
      game_active = 1'b0;
      tick();
      check_eq("drop_jump", jump_clear, 0);
      check_eq("drop_x", player_x, 400);
      check_eq("drop_ready", cmd_ready, 1);
      game_active = 1'b1;
      frame();
      check_eq("drop_lane", player_lane, 1);
      check_eq("drop_flags", {jump_clear, slide_clear, stunned}, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
